// File: rtl/gyruss_input_cond.sv
// Gyruss control conditioning: PS/2 keyboard and two pads merged into the active-low cabinet inputs.
// Define GYRUSS_COIN_PULSE_EN to shape each coin into a fixed-width pulse followed by a lockout.
module gyruss_input_cond #(
    parameter logic [22:0] COIN_PULSE_CYC = 23'd4915200,
    parameter logic [22:0] COIN_LOCK_CYC  = 23'd2457600
) (
    input  logic        clk_49m,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    output logic [3:0]  p1_joystick,
    output logic [3:0]  p2_joystick,
    output logic        p1_fire,
    output logic        p2_fire,
    output logic [1:0]  start_buttons,
    output logic [1:0]  coin,
    output logic        btn_service,
    output logic        m_pause
);

    logic toggle_q;
    logic key_start1, key_start2, key_coin1, key_coin2, key_service, key_pause;
    logic key_up, key_down, key_left, key_right, key_fire;

    logic [3:0] p1_raw, p2_raw;
    logic       p1_fire_raw, p2_fire_raw;
    logic [1:0] start_raw, coin_raw;
    logic       pause_raw;

    logic unused_inputs;
    assign unused_inputs = ^{ps2_key[8], joystick_0[15:9], joystick_1[15:9]};

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            toggle_q    <= 1'b0;
            key_start1  <= 1'b0;
            key_start2  <= 1'b0;
            key_coin1   <= 1'b0;
            key_coin2   <= 1'b0;
            key_service <= 1'b0;
            key_pause   <= 1'b0;
            key_up      <= 1'b0;
            key_down    <= 1'b0;
            key_left    <= 1'b0;
            key_right   <= 1'b0;
            key_fire    <= 1'b0;
        end else begin
            toggle_q <= ps2_key[10];
            if (ps2_key[10] != toggle_q) begin
                case (ps2_key[7:0])
                    8'h16:   key_start1  <= ps2_key[9];
                    8'h1E:   key_start2  <= ps2_key[9];
                    8'h2E:   key_coin1   <= ps2_key[9];
                    8'h36:   key_coin2   <= ps2_key[9];
                    8'h46:   key_service <= ps2_key[9];
                    8'h4D:   key_pause   <= ps2_key[9];
                    8'h75:   key_up      <= ps2_key[9];
                    8'h72:   key_down    <= ps2_key[9];
                    8'h6B:   key_left    <= ps2_key[9];
                    8'h74:   key_right   <= ps2_key[9];
                    8'h14:   key_fire    <= ps2_key[9];
                    default: ;
                endcase
            end
        end
    end

    // Keyboard directions and fire drive both players.
    assign p1_raw      = {key_right | joystick_0[0], key_left | joystick_0[1],
                          key_down  | joystick_0[2], key_up   | joystick_0[3]};
    assign p2_raw      = {key_right | joystick_1[0], key_left | joystick_1[1],
                          key_down  | joystick_1[2], key_up   | joystick_1[3]};
    assign p1_fire_raw = key_fire | joystick_0[4];
    assign p2_fire_raw = key_fire | joystick_1[4];
    assign start_raw   = {key_start2 | joystick_0[7] | joystick_1[7],
                          key_start1 | joystick_0[5] | joystick_1[5]};
    assign coin_raw    = {key_coin2, key_coin1 | joystick_0[6] | joystick_1[6]};
    assign pause_raw   = key_pause | joystick_0[8] | joystick_1[8];

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            p1_joystick   <= 4'hF;
            p2_joystick   <= 4'hF;
            p1_fire       <= 1'b1;
            p2_fire       <= 1'b1;
            start_buttons <= 2'b11;
            btn_service   <= 1'b1;
            m_pause       <= 1'b0;
        end else begin
            p1_joystick   <= ~p1_raw;
            p2_joystick   <= ~p2_raw;
            p1_fire       <= ~p1_fire_raw;
            p2_fire       <= ~p2_fire_raw;
            start_buttons <= ~start_raw;
            btn_service   <= ~key_service;
            m_pause       <= pause_raw;
        end
    end

`ifdef GYRUSS_COIN_PULSE_EN
    typedef enum logic [1:0] {COIN_IDLE, COIN_PULSE, COIN_LOCK} coin_state_t;

    for (genvar ch = 0; ch < 2; ch++) begin : g_coin
        coin_state_t state;
        logic [22:0] cnt;
        logic        prev;
        logic        coin_q;

        // prev resets high so a coin already held at reset release is not an edge.
        always_ff @(posedge clk_49m or negedge reset) begin
            if (!reset) begin
                state  <= COIN_IDLE;
                cnt    <= '0;
                prev   <= 1'b1;
                coin_q <= 1'b1;
            end else begin
                prev <= coin_raw[ch];
                case (state)
                    COIN_IDLE: begin
                        if (coin_raw[ch] && !prev) begin
                            state  <= COIN_PULSE;
                            cnt    <= '0;
                            coin_q <= 1'b0;
                        end
                    end
                    COIN_PULSE: begin
                        if (cnt == COIN_PULSE_CYC - 23'd1) begin
                            state  <= COIN_LOCK;
                            cnt    <= '0;
                            coin_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 23'd1;
                        end
                    end
                    COIN_LOCK: begin
                        if (cnt >= COIN_LOCK_CYC - 23'd1 && !coin_raw[ch]) begin
                            state <= COIN_IDLE;
                            cnt   <= '0;
                        end else if (cnt < COIN_LOCK_CYC - 23'd1) begin
                            cnt <= cnt + 23'd1;
                        end
                    end
                    default: begin
                        state  <= COIN_IDLE;
                        cnt    <= '0;
                        coin_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign coin = {g_coin[1].coin_q, g_coin[0].coin_q};
`else
    logic unused_params;
    assign unused_params = ^{COIN_PULSE_CYC, COIN_LOCK_CYC};

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) coin <= 2'b11;
        else        coin <= ~coin_raw;
    end
`endif

endmodule

// File: tb/tb_gyruss_input_cond.sv
// Bench for gyruss_input_cond: directed steps plus randomized pads/keys against a key-table/timestamp model.
module tb_gyruss_input_cond;

    localparam int P = 8;
    localparam int L = 4;

    logic        clk_49m = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0, joystick_1;
    logic [3:0]  p1_joystick, p2_joystick;
    logic        p1_fire, p2_fire;
    logic [1:0]  start_buttons, coin;
    logic        btn_service, m_pause;

    int checks = 0;
    int errors = 0;

    always #10 clk_49m = ~clk_49m;

    gyruss_input_cond #(
        .COIN_PULSE_CYC(23'(P)),
        .COIN_LOCK_CYC (23'(L))
    ) dut (
        .clk_49m      (clk_49m),
        .reset        (reset),
        .ps2_key      (ps2_key),
        .joystick_0   (joystick_0),
        .joystick_1   (joystick_1),
        .p1_joystick  (p1_joystick),
        .p2_joystick  (p2_joystick),
        .p1_fire      (p1_fire),
        .p2_fire      (p2_fire),
        .start_buttons(start_buttons),
        .coin         (coin),
        .btn_service  (btn_service),
        .m_pause      (m_pause)
    );

    // Reference model: a pressed-key table indexed by scan code, outputs one edge
    // behind their raw OR, and coin pulses as start-edge timestamps.
    logic       kb [256];
    logic       tog_prev;
    int         edge_n;
    logic [1:0] raw_prev;
    bit         idle [2];
    int         ps [2];
    logic [3:0] exp_p1, exp_p2;
    logic       exp_f1, exp_f2, exp_srv, exp_pause;
    logic [1:0] exp_start, exp_coin, craw;

    always @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            foreach (kb[i]) kb[i] = 1'b0;
            tog_prev  = 1'b0;
            edge_n    = 0;
            raw_prev  = 2'b11;
            idle[0]   = 1; idle[1] = 1;
            ps[0]     = 0; ps[1]   = 0;
            exp_p1    = 4'hF; exp_p2 = 4'hF;
            exp_f1    = 1'b1; exp_f2 = 1'b1;
            exp_start = 2'b11; exp_coin = 2'b11;
            exp_srv   = 1'b1; exp_pause = 1'b0;
        end else begin
            edge_n++;
            exp_p1 = ~{kb[8'h74] | joystick_0[0], kb[8'h6B] | joystick_0[1],
                       kb[8'h72] | joystick_0[2], kb[8'h75] | joystick_0[3]};
            exp_p2 = ~{kb[8'h74] | joystick_1[0], kb[8'h6B] | joystick_1[1],
                       kb[8'h72] | joystick_1[2], kb[8'h75] | joystick_1[3]};
            exp_f1 = ~(kb[8'h14] | joystick_0[4]);
            exp_f2 = ~(kb[8'h14] | joystick_1[4]);
            exp_start = ~{kb[8'h1E] | joystick_0[7] | joystick_1[7],
                          kb[8'h16] | joystick_0[5] | joystick_1[5]};
            exp_srv   = ~kb[8'h46];
            exp_pause = kb[8'h4D] | joystick_0[8] | joystick_1[8];
            craw = {kb[8'h36], kb[8'h2E] | joystick_0[6] | joystick_1[6]};
`ifdef GYRUSS_COIN_PULSE_EN
            for (int c = 0; c < 2; c++) begin
                if (idle[c] && craw[c] && !raw_prev[c]) begin
                    idle[c] = 0;
                    ps[c]   = edge_n;
                end else if (!idle[c] && edge_n >= ps[c] + P + L && !craw[c]) begin
                    idle[c] = 1;
                end
                exp_coin[c] = !(!idle[c] && edge_n < ps[c] + P);
            end
            raw_prev = craw;
`else
            exp_coin = ~craw;
`endif
            if (ps2_key[10] != tog_prev) kb[ps2_key[7:0]] = ps2_key[9];
            tog_prev = ps2_key[10];
        end
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("p1_joystick", p1_joystick, exp_p1);
        chk("p2_joystick", p2_joystick, exp_p2);
        chk("p1_fire", {3'b0, p1_fire}, {3'b0, exp_f1});
        chk("p2_fire", {3'b0, p2_fire}, {3'b0, exp_f2});
        chk("start_buttons", {2'b0, start_buttons}, {2'b0, exp_start});
        chk("coin", {2'b0, coin}, {2'b0, exp_coin});
        chk("btn_service", {3'b0, btn_service}, {3'b0, exp_srv});
        chk("m_pause", {3'b0, m_pause}, {3'b0, exp_pause});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_49m);
            check_all();
        end
    endtask

    task automatic key(input logic [7:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    endtask

    task automatic run_count(input int n, input int ch, output int lows, output int falls);
        logic prev;
        lows = 0; falls = 0; prev = coin[ch];
        repeat (n) begin
            @(negedge clk_49m);
            check_all();
            if (!coin[ch]) lows++;
            if (prev && !coin[ch]) falls++;
            prev = coin[ch];
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_p1"}, p1_joystick, 4'hF);
        chk({tag, "_p2"}, p2_joystick, 4'hF);
        chk({tag, "_fires"}, {2'b0, p2_fire, p1_fire}, 4'h3);
        chk({tag, "_start"}, {2'b0, start_buttons}, 4'h3);
        chk({tag, "_coin"}, {2'b0, coin}, 4'h3);
        chk({tag, "_svc_pause"}, {2'b0, btn_service, m_pause}, 4'h2);
    endtask

    logic [7:0] codes [11] = '{8'h16, 8'h1E, 8'h2E, 8'h36, 8'h46, 8'h4D,
                               8'h75, 8'h72, 8'h6B, 8'h74, 8'h14};

    initial begin
        int lo, fa, lo2, fa2, lo3, fa3, both, mixed, sel;
        reset = 1'b0; ps2_key = '0; joystick_0 = '0; joystick_1 = '0;

        step(3);
        check_reset_values("in_reset");
        @(negedge clk_49m) reset = 1'b1;
        step(3);
        check_reset_values("after_release");

        // Keyboard up: visible two edges after the toggle, on both players.
        key(8'h75, 1'b1);
        step(1);
        chk("kbd_up_1cyc", p1_joystick, 4'hF);
        step(1);
        chk("kbd_up_p1", p1_joystick, 4'hE);
        chk("kbd_up_p2", p2_joystick, 4'hE);
        key(8'h75, 1'b0);
        step(2);
        chk("kbd_up_rel", p1_joystick, 4'hF);
        key(8'h99, 1'b1);
        step(3);
        check_reset_values("unlisted_code");

        // Pad change visible one edge later.
        joystick_0[4] = 1'b1; joystick_1[0] = 1'b1;
        step(1);
        chk("pad_fire1", {3'b0, p1_fire}, 4'h0);
        chk("pad_p2_right", p2_joystick, 4'h7);
        joystick_0 = '0; joystick_1 = '0;
        step(2);

        // Coin1 held 100 cycles, then a second press.
        joystick_0[6] = 1'b1;
        run_count(100, 0, lo, fa);
`ifdef GYRUSS_COIN_PULSE_EN
        chk_int("coin1_hold_lows", lo, P);
`else
        chk_int("coin1_hold_lows", lo, 100);
`endif
        chk_int("coin1_hold_pulses", fa, 1);
        joystick_0[6] = 1'b0;
        step(6);
        joystick_0[6] = 1'b1;
        step(1);
        chk("coin1_latency", {3'b0, coin[0]}, 4'h0);
        run_count(19, 0, lo, fa);
`ifdef GYRUSS_COIN_PULSE_EN
        chk_int("coin1_second_lows", lo, P - 1);
`else
        chk_int("coin1_second_lows", lo, 19);
`endif
        joystick_0[6] = 1'b0;
        step(20);

        // Release right after the pulse, re-press inside lockout.
        joystick_0[6] = 1'b1;
        run_count(8, 0, lo, fa);
        joystick_0[6] = 1'b0;
        run_count(1, 0, lo2, fa2);
        joystick_0[6] = 1'b1;
        run_count(30, 0, lo3, fa3);
`ifdef GYRUSS_COIN_PULSE_EN
        chk_int("lockout_lows", lo + lo2 + lo3, P);
        chk_int("lockout_pulses", fa + fa2 + fa3, 1);
`else
        chk_int("lockout_lows", lo + lo2 + lo3, 38);
        chk_int("lockout_pulses", fa + fa2 + fa3, 2);
`endif
        joystick_0[6] = 1'b0;
        step(3);
        joystick_0[6] = 1'b1;
        run_count(20, 0, lo, fa);
`ifdef GYRUSS_COIN_PULSE_EN
        chk_int("fresh_edge_lows", lo, P);
`else
        chk_int("fresh_edge_lows", lo, 20);
`endif
        joystick_0[6] = 1'b0;
        step(20);

        // Keyboard coin2 and pad coin1 arriving on the same raw edge.
        key(8'h36, 1'b1);
        step(1);
        joystick_1[6] = 1'b1;
        both = 0; mixed = 0;
        repeat (12) begin
            @(negedge clk_49m);
            check_all();
            if (coin == 2'b00) both++;
            if (coin == 2'b01 || coin == 2'b10) mixed++;
        end
`ifdef GYRUSS_COIN_PULSE_EN
        chk_int("dual_coin_low", both, P);
`else
        chk_int("dual_coin_low", both, 12);
`endif
        chk_int("dual_coin_skew", mixed, 0);
        key(8'h36, 1'b0);
        joystick_1[6] = 1'b0;
        step(20);

        // Reset in the middle of a pulse with the coin still held.
        joystick_0[6] = 1'b1;
        step(3);
        reset = 1'b0;
        #1;
        chk("reset_mid_pulse", {2'b0, coin}, 4'h3);
        step(2);
        reset = 1'b1;
        run_count(20, 0, lo, fa);
`ifdef GYRUSS_COIN_PULSE_EN
        chk_int("held_at_release_lows", lo, 0);
`else
        chk_int("held_at_release_lows", lo, 20);
`endif
        joystick_0[6] = 1'b0;
        step(20);

        // Randomized pads and key events.
        repeat (500) begin
            if ($urandom_range(0, 7) == 0) joystick_0 = 16'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) joystick_1 = 16'($urandom_range(0, 511));
            if ($urandom_range(0, 5) == 0) begin
                sel = $urandom_range(0, 11);
                key(sel == 11 ? 8'($urandom) : codes[sel], 1'($urandom));
            end
            step(1);
        end
        joystick_0 = '0; joystick_1 = '0;
        step(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gyruss_input_cond.md
GYRUSS_INPUT_COND -- requirements
Module: gyruss_input_cond

Interface
REQ-001 Parameter COIN_PULSE_CYC, 23'd4915200: coin pulse width in clk_49m cycles (100 ms); minimum 1.
REQ-002 Parameter COIN_LOCK_CYC, 23'd2457600: minimum post-pulse lockout in clk_49m cycles (50 ms); minimum 1.
REQ-003 clk_49m  in  1  sole clock, 49.152 MHz.
REQ-004 reset  in  1  asynchronous, active-low; 0 = reset.
REQ-005 ps2_key  in  11  [10] toggle strobe, [9] pressed, [8] extended (ignored), [7:0] scan code.
REQ-006 joystick_0  in  16  P1 pad, active-high: [0] R, [1] L, [2] D, [3] U, [4] fire, [5] start1, [6] coin1, [7] start2, [8] pause.
REQ-007 joystick_1  in  16  P2 pad, same layout.
REQ-008 p1_joystick  out  4  active-low {right,left,down,up}.
REQ-009 p2_joystick  out  4  active-low {right,left,down,up}.
REQ-010 p1_fire, p2_fire  out  1 each  active-low fire.
REQ-011 start_buttons  out  2  active-low {start2,start1}.
REQ-012 coin  out  2  active-low shaped coins {coin2,coin1}.
REQ-013 btn_service  out  1  active-low service.
REQ-014 m_pause  out  1  active-high pause request.

Function
REQ-015 Keyboard latch: ps2_key[10] registered each cycle; on inequality with registered copy, key state for ps2_key[7:0] SHALL become ps2_key[9] on that edge.
REQ-016 Scan codes: 16 start1, 1E start2, 2E coin1, 36 coin2, 46 service, 4D pause, 75 up, 72 down, 6B left, 74 right, 14 fire; other codes SHALL change no state.
REQ-017 Keyboard directions/fire SHALL apply to both players; per-player raw = key OR own pad bit.
REQ-018 Raw start1 = key | j0[5] | j1[5]; start2 = key | j0[7] | j1[7]; coin1 raw = key | j0[6] | j1[6]; coin2 raw = key only; pause = key | j0[8] | j1[8].
REQ-019 All outputs SHALL be registered: pad change visible 1 cycle later; keyboard event visible 2 cycles after toggle change.
REQ-020 Each coin channel SHALL run an independent FSM: IDLE, PULSE, LOCK.
REQ-021 IDLE: coin output high; raw coin 0->1 edge (vs. previous-cycle raw) -> PULSE, counter cleared.
REQ-022 PULSE: coin output low for exactly COIN_PULSE_CYC cycles, regardless of raw; then -> LOCK, counter cleared.
REQ-023 LOCK: coin output high; -> IDLE once counter reached COIN_LOCK_CYC AND raw coin is 0; raw held indefinitely SHALL hold LOCK.
REQ-024 Edges during PULSE or LOCK SHALL be ignored, not queued.
REQ-025 Raw coin already 1 when reset releases SHALL NOT produce a pulse (edge register reset to 1).
REQ-026 Simultaneous coin1/coin2 edges SHALL produce overlapping independent pulses.
REQ-027 Counters 23-bit, saturating in LOCK; no wrap.

Reset
REQ-028 While reset=0: all key states 0, toggle copy 0, coin FSMs IDLE, counters 0.
REQ-029 Reset outputs: p1/p2_joystick 4'hF, fires 1, start_buttons 2'b11, coin 2'b11, btn_service 1, m_pause 0.
REQ-030 Reset asserted mid-PULSE SHALL immediately force coin output high; no pulse resumes on release.

Configuration
REQ-031 Macro GYRUSS_COIN_PULSE_EN defined: coin shaped per REQ-020..027.
REQ-032 Macro undefined: FSMs and counters omitted; coin = registered ~raw coin (1-cycle latency); parameters unused.

Verification (COIN_PULSE_CYC=8, COIN_LOCK_CYC=4)
REQ-033 Reset low, all inputs 0 -> outputs at REQ-029 values; release -> unchanged.
REQ-034 ps2_key toggles with {pressed=1,code=75} -> p1_joystick and p2_joystick = 4'hE 2 cycles later; toggle with pressed=0 -> 4'hF.
REQ-035 joystick_0[6] held high 100 cycles -> coin[0] low exactly 8 cycles, single pulse; release then re-press after 4+ cycles -> second 8-cycle pulse.
REQ-036 coin1 pulse, release at cycle 9, re-press at cycle 10 -> no pulse until lockout expires and a fresh edge occurs.
REQ-037 Keyboard coin2 and joystick_1[6] pressed same cycle -> coin = 2'b00 for 8 cycles, both channels rise together.
REQ-038 Reset pulled low at PULSE cycle 3 -> coin[0] high immediately; raw still 1 on release -> no pulse; macro undefined build -> coin[0] tracks ~raw with 1-cycle latency.
